// File: rtl/sim_timer_dev.sv
// Machine timer (mtime/mtimecmp) with a level interrupt, on a single-cycle device bus.
// Optional PRESCALE register and tick divider enabled by defining SIM_TIMER_PRESCALE_EN.
module sim_timer_dev #(
  parameter int unsigned TimerWidth    = 64,
  parameter int unsigned PrescaleWidth = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dev_req_i,
  input  logic        dev_we_i,
  input  logic [31:0] dev_addr_i,
  input  logic [3:0]  dev_be_i,
  input  logic [31:0] dev_wdata_i,
  output logic        dev_rvalid_o,
  output logic [31:0] dev_rdata_o,
  output logic        dev_err_o,
  output logic        timer_irq_o
);

  localparam logic [9:0] OffMtimeLo    = 10'h000;
  localparam logic [9:0] OffMtimeHi    = 10'h004;
  localparam logic [9:0] OffMtimecmpLo = 10'h008;
  localparam logic [9:0] OffMtimecmpHi = 10'h00C;
  localparam logic [9:0] OffCtrl       = 10'h010;
`ifdef SIM_TIMER_PRESCALE_EN
  localparam logic [9:0] OffPrescale   = 10'h014;
`endif

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [TimerWidth-1:0] mtime_q, mtime_d;
  logic [TimerWidth-1:0] mtimecmp_q, mtimecmp_d;
  logic [63:0]           mtime_ext_s, mtimecmp_ext_s;
  logic [63:0]           mtime_wr_s, mtimecmp_wr_s;
  logic                  en_q, en_d;
  logic                  tick_s;
  logic                  hit_s;
  logic                  wr_s;
  logic [9:0]            off_s;
  logic [31:0]           rd_word_s;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic                  unused_s;

  assign off_s          = dev_addr_i[9:0];
  assign mtime_ext_s    = 64'(mtime_q);
  assign mtimecmp_ext_s = 64'(mtimecmp_q);
  assign wr_s           = dev_req_i & dev_we_i & hit_s & (|dev_be_i);
  assign unused_s       = (^dev_addr_i[31:10]) ^ (PrescaleWidth == 32'd0);

`ifdef SIM_TIMER_PRESCALE_EN
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic [PrescaleWidth-1:0] pcnt_q, pcnt_d;

  // Prescale divider: tick when the counter reaches PRESCALE; any PRESCALE write restarts it.
  always_comb begin
    tick_s     = en_q && (pcnt_q == prescale_q);
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    if (wr_s && (off_s == OffPrescale)) begin
      prescale_d = PrescaleWidth'(be_merge(32'(prescale_q), dev_wdata_i, dev_be_i));
      pcnt_d     = {PrescaleWidth{1'b0}};
    end else if (tick_s) begin
      pcnt_d     = {PrescaleWidth{1'b0}};
    end else if (en_q) begin
      pcnt_d     = pcnt_q + {{(PrescaleWidth-1){1'b0}}, 1'b1};
    end else begin
      pcnt_d     = pcnt_q;
    end
  end

  // Prescale state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale_q <= {PrescaleWidth{1'b0}};
      pcnt_q     <= {PrescaleWidth{1'b0}};
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end
`else
  assign tick_s = en_q;
`endif

  // Address decode and read mux; misaligned offsets never match an entry.
  always_comb begin
    hit_s     = 1'b0;
    rd_word_s = 32'h0000_0000;
    if (dev_addr_i[1:0] == 2'b00) begin
      case (off_s)
        OffMtimeLo: begin
          hit_s     = 1'b1;
          rd_word_s = mtime_ext_s[31:0];
        end
        OffMtimeHi: begin
          hit_s     = 1'b1;
          rd_word_s = mtime_ext_s[63:32];
        end
        OffMtimecmpLo: begin
          hit_s     = 1'b1;
          rd_word_s = mtimecmp_ext_s[31:0];
        end
        OffMtimecmpHi: begin
          hit_s     = 1'b1;
          rd_word_s = mtimecmp_ext_s[63:32];
        end
        OffCtrl: begin
          hit_s     = 1'b1;
          rd_word_s = {31'h0000_0000, en_q};
        end
`ifdef SIM_TIMER_PRESCALE_EN
        OffPrescale: begin
          hit_s     = 1'b1;
          rd_word_s = 32'(prescale_q);
        end
`endif
        default: begin
          hit_s     = 1'b0;
          rd_word_s = 32'h0000_0000;
        end
      endcase
    end else begin
      hit_s     = 1'b0;
      rd_word_s = 32'h0000_0000;
    end
  end

  // mtime next state: a bus write wins over the increment in the same cycle.
  always_comb begin
    mtime_wr_s = mtime_ext_s;
    mtime_d    = mtime_q;
    if (wr_s && (off_s == OffMtimeLo)) begin
      mtime_wr_s[31:0]  = be_merge(mtime_ext_s[31:0], dev_wdata_i, dev_be_i);
      mtime_d           = TimerWidth'(mtime_wr_s);
    end else if (wr_s && (off_s == OffMtimeHi)) begin
      mtime_wr_s[63:32] = be_merge(mtime_ext_s[63:32], dev_wdata_i, dev_be_i);
      mtime_d           = TimerWidth'(mtime_wr_s);
    end else if (tick_s) begin
      mtime_d           = mtime_q + {{(TimerWidth-1){1'b0}}, 1'b1};
    end else begin
      mtime_d           = mtime_q;
    end
  end

  // mtimecmp and CTRL next state from bus writes.
  always_comb begin
    mtimecmp_wr_s = mtimecmp_ext_s;
    mtimecmp_d    = mtimecmp_q;
    en_d          = en_q;
    if (wr_s && (off_s == OffMtimecmpLo)) begin
      mtimecmp_wr_s[31:0]  = be_merge(mtimecmp_ext_s[31:0], dev_wdata_i, dev_be_i);
      mtimecmp_d           = TimerWidth'(mtimecmp_wr_s);
    end else if (wr_s && (off_s == OffMtimecmpHi)) begin
      mtimecmp_wr_s[63:32] = be_merge(mtimecmp_ext_s[63:32], dev_wdata_i, dev_be_i);
      mtimecmp_d           = TimerWidth'(mtimecmp_wr_s);
    end else if (wr_s && (off_s == OffCtrl) && dev_be_i[0]) begin
      en_d                 = dev_wdata_i[0];
    end else begin
      en_d                 = en_q;
    end
  end

  // Response: one cycle after every request, data only for mapped reads.
  always_comb begin
    rvalid_d = dev_req_i;
    err_d    = dev_req_i & ~hit_s;
    if (dev_req_i && !dev_we_i && hit_s) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = 32'h0000_0000;
    end
    irq_d    = (mtime_q >= mtimecmp_q);
  end

  // Timer state and registered bus/interrupt outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= {TimerWidth{1'b0}};
      mtimecmp_q <= {TimerWidth{1'b1}};
      en_q       <= 1'b1;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_err_o    = err_q;
  assign dev_rdata_o  = rdata_q;
  assign timer_irq_o  = irq_q;

endmodule

// File: tb/tb_sim_timer_dev.sv
// Self-checking bench for sim_timer_dev: directed scenarios plus random bus traffic
// checked every cycle against a register-level reference model.
module tb_sim_timer_dev;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        dev_req_i;
  logic        dev_we_i;
  logic [31:0] dev_addr_i;
  logic [3:0]  dev_be_i;
  logic [31:0] dev_wdata_i;
  logic        dev_rvalid_o;
  logic [31:0] dev_rdata_o;
  logic        dev_err_o;
  logic        timer_irq_o;

  int checks = 0;
  int errors = 0;

  sim_timer_dev #(.TimerWidth(64), .PrescaleWidth(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .dev_req_i    (dev_req_i),
    .dev_we_i     (dev_we_i),
    .dev_addr_i   (dev_addr_i),
    .dev_be_i     (dev_be_i),
    .dev_wdata_i  (dev_wdata_i),
    .dev_rvalid_o (dev_rvalid_o),
    .dev_rdata_o  (dev_rdata_o),
    .dev_err_o    (dev_err_o),
    .timer_irq_o  (timer_irq_o)
  );

  always #5 clk = ~clk;

  // Reference model state (64-bit timer)
  logic [63:0] m_mtime, m_cmp;
  logic        m_en;
`ifdef SIM_TIMER_PRESCALE_EN
  logic [7:0]  m_ps, m_pc;
`endif
  logic        exp_rvalid, exp_err, exp_irq;
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mtime = 64'd0;
    m_cmp   = {64{1'b1}};
    m_en    = 1'b1;
`ifdef SIM_TIMER_PRESCALE_EN
    m_ps    = 8'd0;
    m_pc    = 8'd0;
`endif
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic is_mapped(input logic [9:0] off);
    if (off[1:0] != 2'b00) return 1'b0;
`ifdef SIM_TIMER_PRESCALE_EN
    return off <= 10'h014;
`else
    return off <= 10'h010;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] off);
    case (off)
      10'h000: return m_mtime[31:0];
      10'h004: return m_mtime[63:32];
      10'h008: return m_cmp[31:0];
      10'h00C: return m_cmp[63:32];
      10'h010: return {31'd0, m_en};
`ifdef SIM_TIMER_PRESCALE_EN
      10'h014: return {24'd0, m_ps};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, clock, advance the model, then check every output.
  task automatic step(input logic req, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd);
    logic [9:0]  off;
    logic        mapped, tick;
    logic [63:0] nx_mtime, nx_cmp;
    logic        nx_en;
    dev_req_i   = req;
    dev_we_i    = we;
    dev_addr_i  = addr;
    dev_be_i    = be;
    dev_wdata_i = wd;
    @(posedge clk);
    off        = addr[9:0];
    mapped     = is_mapped(off);
    exp_irq    = (m_mtime >= m_cmp);
    exp_rvalid = req;
    exp_err    = req && !mapped;
    exp_rdata  = (req && !we && mapped) ? m_read(off) : 32'd0;
`ifdef SIM_TIMER_PRESCALE_EN
    tick = m_en && (m_pc == m_ps);
    if (tick) m_pc = 8'd0;
    else if (m_en) m_pc = m_pc + 8'd1;
`else
    tick = m_en;
`endif
    nx_mtime = tick ? m_mtime + 64'd1 : m_mtime;
    nx_cmp   = m_cmp;
    nx_en    = m_en;
    if (req && we && mapped && (be != 4'b0000)) begin
      case (off)
        10'h000: nx_mtime = {m_mtime[63:32], merge(m_mtime[31:0], wd, be)};
        10'h004: nx_mtime = {merge(m_mtime[63:32], wd, be), m_mtime[31:0]};
        10'h008: nx_cmp   = {m_cmp[63:32], merge(m_cmp[31:0], wd, be)};
        10'h00C: nx_cmp   = {merge(m_cmp[63:32], wd, be), m_cmp[31:0]};
        10'h010: if (be[0]) nx_en = wd[0];
`ifdef SIM_TIMER_PRESCALE_EN
        10'h014: begin
          m_ps = merge({24'd0, m_ps}, wd, be) & 32'hFF;
          m_pc = 8'd0;
        end
`endif
        default: ;
      endcase
    end
    m_mtime = nx_mtime;
    m_cmp   = nx_cmp;
    m_en    = nx_en;
    #1;
    chk("rvalid", dev_rvalid_o, exp_rvalid);
    chk("err", dev_err_o, exp_err);
    chk("rdata", dev_rdata_o, exp_rdata);
    chk("irq", timer_irq_o, exp_irq);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_rvalid"}, dev_rvalid_o, 1'b0);
    chk({tag, "_err"}, dev_err_o, 1'b0);
    chk({tag, "_rdata"}, dev_rdata_o, 32'd0);
    chk({tag, "_irq"}, timer_irq_o, 1'b0);
  endtask

  initial begin
    logic [31:0] r1, r2, rnd, a, rb;
    int          lat, pick;

    rst_ni = 1'b0; dev_req_i = 1'b0; dev_we_i = 1'b0;
    dev_addr_i = 32'd0; dev_be_i = 4'h0; dev_wdata_i = 32'd0;
    m_reset();
    #3;
    outs_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    outs_zero("reset_hold");
    rst_ni = 1'b1;

    // mtime advances one per cycle: reads 8 cycles apart differ by 8
    step(1'b1, 1'b0, 32'h0, 4'hF, 32'd0); r1 = dev_rdata_o;
    repeat (7) idle();
    step(1'b1, 1'b0, 32'h0, 4'hF, 32'd0); r2 = dev_rdata_o;
    chk("mtime_delta", r2 - r1, 32'd8);

    // Compare: irq rises 17 cycles after MTIME_LO=0x10 with MTIMECMP=0x20
    step(1'b1, 1'b1, 32'h00C, 4'hF, 32'h0);
    step(1'b1, 1'b1, 32'h008, 4'hF, 32'h20);
    step(1'b1, 1'b1, 32'h000, 4'hF, 32'h10);
    lat = -1;
    for (int i = 1; i <= 24; i++) begin
      idle();
      if (lat < 0 && i > 1 && timer_irq_o === 1'b1) lat = i;
    end
    chk("irq_rise_latency", lat, 17);
    step(1'b1, 1'b1, 32'h008, 4'hF, 32'hFFFF_FFFF);
    idle();
    chk("irq_fall", timer_irq_o, 1'b0);

    // 64-bit wrap
    step(1'b1, 1'b1, 32'h004, 4'hF, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h000, 4'hF, 32'hFFFF_FFFE);
    idle(); idle();
    step(1'b1, 1'b0, 32'h000, 4'hF, 32'd0);
    chk("wrap_lo", dev_rdata_o, 32'd0);
    step(1'b1, 1'b0, 32'h004, 4'hF, 32'd0);
    chk("wrap_hi", dev_rdata_o, 32'd0);

    // Misaligned / unmapped / empty byte-enable accesses
    step(1'b1, 1'b0, 32'h002, 4'hF, 32'd0);
    chk("misaligned_err", dev_err_o, 1'b1);
    step(1'b1, 1'b1, 32'h3FC, 4'hF, 32'hDEAD_BEEF);
    chk("unmapped_err", dev_err_o, 1'b1);
    step(1'b1, 1'b1, 32'h008, 4'h0, 32'h0);
    chk("be0_err", dev_err_o, 1'b0);
    step(1'b1, 1'b0, 32'h008, 4'hF, 32'd0);
    chk("be0_nochange", dev_rdata_o, 32'hFFFF_FFFF);

    // EN=0 freezes mtime
    step(1'b1, 1'b1, 32'h010, 4'h1, 32'h0);
    step(1'b1, 1'b0, 32'h000, 4'hF, 32'd0); r1 = dev_rdata_o;
    repeat (5) idle();
    step(1'b1, 1'b0, 32'h000, 4'hF, 32'd0); r2 = dev_rdata_o;
    chk("en0_frozen", r2 - r1, 32'd0);
    step(1'b1, 1'b0, 32'h010, 4'hF, 32'd0);
    chk("ctrl_read", dev_rdata_o, 32'd0);
    step(1'b1, 1'b1, 32'h010, 4'hF, 32'hFFFF_FFFF);

`ifdef SIM_TIMER_PRESCALE_EN
    step(1'b1, 1'b1, 32'h014, 4'hF, 32'd3);
    step(1'b1, 1'b0, 32'h000, 4'hF, 32'd0); r1 = dev_rdata_o;
    repeat (7) idle();
    step(1'b1, 1'b0, 32'h000, 4'hF, 32'd0); r2 = dev_rdata_o;
    chk("prescale_delta", r2 - r1, 32'd2);
    step(1'b1, 1'b1, 32'h014, 4'hF, 32'd0);
`else
    step(1'b1, 1'b0, 32'h014, 4'hF, 32'd0);
    chk("prescale_unmapped", dev_err_o, 1'b1);
`endif

    // Random bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      rnd  = $urandom();
      rb   = $urandom();
      pick = $urandom_range(0, 7);
      if (pick <= 5) begin
        a = {rnd[31:10], 10'(pick * 4)};
      end else if (pick == 6) begin
        a = rnd;
        if (a[1:0] == 2'b00) a[0] = 1'b1;
      end else begin
        a = {rnd[31:10], 10'(24 + 4 * $urandom_range(0, 249))};
      end
      step(rb[4], rb[5], a, rb[3:0], $urandom());
    end

    // Reset while a read request is pending: response is dropped
    dev_req_i = 1'b1; dev_we_i = 1'b0; dev_addr_i = 32'h0; dev_be_i = 4'hF;
    #2;
    rst_ni = 1'b0;
    #1;
    outs_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    outs_zero("midrst_hold");
    dev_req_i = 1'b0;
    m_reset();
    rst_ni = 1'b1;
    repeat (3) idle();
    step(1'b1, 1'b0, 32'h008, 4'hF, 32'd0);
    chk("post_rst_cmp", dev_rdata_o, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
